// File: rtl/key_expand_ctrl_pkg.sv
// key_expand_ctrl_pkg
// Shared definitions for the iterative AES-128 key-schedule sequencer:
// widths, FSM state encodings, round-constant values, the AES S-box table
// and small GF(2^8)/word helper functions.
// No ports (package).
package key_expand_ctrl_pkg;

  localparam int BYTE   = 8;
  localparam int DWORD  = 32;
  localparam int LENGTH = 128;
  localparam int ROUNDS = 10;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  // FSM encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_OUT    = 3'd2;
  localparam logic [2:0] ST_EXPAND = 3'd3;
  localparam logic [2:0] ST_FIN    = 3'd4;

  localparam logic [BYTE-1:0] RCON_INIT  = 8'h01;
  localparam logic [BYTE-1:0] XTIME_POLY = 8'h1b;

  // AES S-box, one 16-byte row per high nibble; byte 0 of a row sits in
  // the top bits so the table reads like the published one.
  localparam logic [127:0] SBOX_ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [BYTE-1:0] sbox(input logic [BYTE-1:0] b);
    logic [127:0] row;
    logic [6:0]   sh;
    row = SBOX_ROWS[b[7:4]];
    sh  = 7'd120 - {b[3:0], 3'b000};
    return row[sh +: 8];
  endfunction

  // Multiply by x in GF(2^8)
  function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? XTIME_POLY : 8'h00);
  endfunction

  function automatic logic [DWORD-1:0] rot_word(input logic [DWORD-1:0] x);
    return {x[23:0], x[31:24]};
  endfunction

endpackage

// File: rtl/key_expand_ctrl_step.sv
// sub_word / key_word_step
// sub_word: SubWord, four parallel combinational S-box lookups.
//   word [31:0] in  - operand
//   sub  [31:0] out - byte-wise S-box of word
// key_word_step: combinational next-word computation of the key schedule.
//   word_idx  [1:0]  in  - position of the word being replaced (0..3)
//   cur_word  [31:0] in  - current w[word_idx]
//   prev_word [31:0] in  - already-updated w[word_idx-1] (unused for idx 0)
//   sub_rot   [31:0] in  - SubWord(RotWord(w3))
//   rcon      [7:0]  in  - round constant for this round
//   next_word [31:0] out - replacement value for w[word_idx]
module sub_word
  import key_expand_ctrl_pkg::*;
(
  input  logic [DWORD-1:0] word,
  output logic [DWORD-1:0] sub
);

  assign sub = {sbox(word[31:24]), sbox(word[23:16]),
                sbox(word[15:8]),  sbox(word[7:0])};

endmodule

module key_word_step
  import key_expand_ctrl_pkg::*;
(
  input  logic [1:0]       word_idx,
  input  logic [DWORD-1:0] cur_word,
  input  logic [DWORD-1:0] prev_word,
  input  logic [DWORD-1:0] sub_rot,
  input  logic [BYTE-1:0]  rcon,
  output logic [DWORD-1:0] next_word
);

  always_comb begin
    next_word = cur_word ^ prev_word;
    if (word_idx == 2'd0) begin
      next_word = cur_word ^ sub_rot ^ {rcon, 24'h000000};
    end
  end

endmodule

// File: rtl/key_expand_ctrl.sv
// key_expand_ctrl
// Iterative AES-128 key-schedule sequencer. Expands key_in into round keys
// 0..10, one 32-bit word per cycle through a single shared SubWord, and
// presents each 128-bit round key on a valid/ready stream.
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    begin expansion of key_in (sampled only in IDLE)
//   key_in     in   128  cipher key, word0 at [127:96]
//   busy       out  1    high in every state except IDLE
//   rk_valid   out  1    rk_out / rk_round valid
//   rk_ready   in   1    consumer accepts the round key
//   rk_out     out  128  current round key, word0 at [127:96]
//   rk_round   out  4    round index of rk_out
//   done       out  1    one-cycle pulse after the round-10 handshake
//   dbg_state  out  3    current FSM state encoding
//
// Handshake: a round key transfers on a rising edge where rk_valid and
// rk_ready are both high. While rk_valid is high and rk_ready low, rk_out
// and rk_round hold; rk_valid never drops without a transfer (except reset).
// rk_ready has no effect outside OUT.
module key_expand_ctrl
  import key_expand_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LENGTH-1:0] key_in,
  output logic              busy,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [LENGTH-1:0] rk_out,
  output logic [3:0]        rk_round,
  output logic              done,
  output logic [2:0]        dbg_state
);

  logic [2:0]       state;
  logic [1:0]       word_idx;
  logic [BYTE-1:0]  rcon;
  logic [DWORD-1:0] w [4];

  logic [DWORD-1:0] rot_w3;
  logic [DWORD-1:0] sub_rot;
  logic [DWORD-1:0] cur_word;
  logic [DWORD-1:0] prev_word;
  logic [DWORD-1:0] next_word;

  // The SubWord operand is always RotWord(w3); only idx 0 uses the result.
  assign rot_w3    = rot_word(w[3]);
  assign cur_word  = w[word_idx];
  assign prev_word = w[word_idx - 2'd1];

  sub_word u_sub_word (
    .word (rot_w3),
    .sub  (sub_rot)
  );

  key_word_step u_step (
    .word_idx  (word_idx),
    .cur_word  (cur_word),
    .prev_word (prev_word),
    .sub_rot   (sub_rot),
    .rcon      (rcon),
    .next_word (next_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      word_idx <= 2'd0;
      rcon     <= RCON_INIT;
      rk_out   <= '0;
      rk_round <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        w[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            w[0]     <= key_in[127:96];
            w[1]     <= key_in[95:64];
            w[2]     <= key_in[63:32];
            w[3]     <= key_in[31:0];
            rcon     <= RCON_INIT;
            word_idx <= 2'd0;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          rk_out   <= {w[0], w[1], w[2], w[3]};
          rk_round <= 4'd0;
          state    <= ST_OUT;
        end
        ST_OUT: begin
          if (rk_ready) begin
            if (rk_round == LAST_ROUND) begin
              state <= ST_FIN;
            end else begin
              word_idx <= 2'd0;
              state    <= ST_EXPAND;
            end
          end
        end
        ST_EXPAND: begin
          w[word_idx] <= next_word;
          word_idx    <= word_idx + 2'd1;
          if (word_idx == 2'd3) begin
            // w3 is still the old value in the register; use the fresh one.
            rk_out   <= {w[0], w[1], w[2], next_word};
            rk_round <= rk_round + 4'd1;
            rcon     <= xtime(rcon);
            state    <= ST_OUT;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign rk_valid  = (state == ST_OUT);
  assign done      = (state == ST_FIN);
  assign dbg_state = state;

endmodule

// File: tb/tb_key_expand_ctrl.sv
// tb_key_expand_ctrl
// Directed bench for key_expand_ctrl using the FIPS-197 key-expansion
// example; expected round keys and cycle timing are hand-entered constants.
module tb_key_expand_ctrl;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h00112233445566778899aabbccddeeff;

  // clock / reset
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         done;
  logic [2:0]   dbg_state;

  always #5 clk = ~clk;

  key_expand_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_out    (rk_out),
    .rk_round  (rk_round),
    .done      (done),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_key [11];

  // scoreboard helpers
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    start    = 1'b0;
    rk_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // rk_ready tied high; start presented before edge 0, so cycle k follows
  // edge k-1. In hold mode start stays high and a second run begins at
  // cycle 55 (start sampled in IDLE at the end of cycle 54).
  task automatic run_tied(input string tag, input int restart_at, input bit hold, input int ncycles);
    int   kk;
    int   r;
    logic ev;
    @(negedge clk);
    start    = 1'b1;
    key_in   = KEY_A;
    rk_ready = 1'b1;
    for (int k = 1; k <= ncycles; k++) begin
      @(negedge clk);
      kk = (hold && k > 54) ? k - 54 : k;
      ev = (kk >= 2 && kk <= 52 && ((kk - 2) % 5) == 0);
      chk_bit({tag, "_busy"}, busy, (kk >= 1 && kk <= 53));
      chk_bit({tag, "_valid"}, rk_valid, ev);
      chk_bit({tag, "_done"}, done, (kk == 53));
      if (ev) begin
        r = (kk - 2) / 5;
        chk({tag, "_round"}, 128'(rk_round), 128'(r));
        chk({tag, "_key"}, rk_out, exp_key[r]);
      end
      if (!hold) begin
        start  = (restart_at > 0 && k >= restart_at && k < restart_at + 3);
        key_in = start ? KEY_B : KEY_A;
      end
    end
    start = 1'b0;
  endtask

  // rk_ready random ~30% high; every transfer must deliver the next key.
  task automatic run_random();
    int           nr      = 0;
    int           dones   = 0;
    int           guard   = 0;
    logic         hold_prev = 1'b0;
    logic [127:0] prev_out = '0;
    logic [3:0]   prev_round = '0;
    logic         rdy;
    @(negedge clk);
    start    = 1'b1;
    key_in   = KEY_A;
    rk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (guard < 600 && !(dones > 0 && !busy)) begin
      if (hold_prev) begin
        chk_bit("rnd_stall_valid", rk_valid, 1'b1);
        chk("rnd_stall_key", rk_out, prev_out);
        chk("rnd_stall_round", 128'(rk_round), 128'(prev_round));
      end
      if (rk_valid) begin
        chk("rnd_round", 128'(rk_round), 128'(nr));
        chk("rnd_key", rk_out, exp_key[(nr > 10) ? 10 : nr]);
      end
      if (done) dones++;
      rdy        = ($urandom_range(0, 9) < 3);
      rk_ready   = rdy;
      hold_prev  = rk_valid && !rdy;
      prev_out   = rk_out;
      prev_round = rk_round;
      if (rk_valid && rdy) nr++;
      guard++;
      @(negedge clk);
    end
    chk("rnd_transfers", 128'(nr), 128'(11));
    chk("rnd_done_pulses", 128'(dones), 128'(1));
    chk_bit("rnd_idle_at_end", busy, 1'b0);
    rk_ready = 1'b0;
  endtask

  initial begin
    int wait_n;
    exp_key[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_key[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_key[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_key[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_key[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_key[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_key[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_key[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_key[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_key[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_key[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst_n    = 1'b0;
    start    = 1'b0;
    rk_ready = 1'b0;
    key_in   = '0;

    // reset state
    #12;
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_valid", rk_valid, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    chk("rst_rk_out", rk_out, 128'h0);
    chk("rst_rk_round", 128'(rk_round), 128'h0);
    chk("rst_state", 128'(dbg_state), 128'(3'd0));
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 key, ready tied high, cycle-exact timing
    run_tied("t1", 0, 1'b0, 56);

    // random backpressure
    do_reset();
    run_random();

    // second start during round 4 with another key is ignored
    do_reset();
    run_tied("t3", 22, 1'b0, 56);

    // async reset while expanding round 6
    do_reset();
    @(negedge clk);
    start    = 1'b1;
    key_in   = KEY_A;
    rk_ready = 1'b1;
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("t4_state_expand", 128'(dbg_state), 128'(3'd3));
    chk("t4_round5", 128'(rk_round), 128'(5));
    #2;
    rst_n = 1'b0;
    #1;
    chk_bit("t4_busy", busy, 1'b0);
    chk_bit("t4_valid", rk_valid, 1'b0);
    chk_bit("t4_done", done, 1'b0);
    chk("t4_rk_out", rk_out, 128'h0);
    chk("t4_rk_round", 128'(rk_round), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start  = 1'b1;
    key_in = 128'h0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk_bit("t4_zero_valid", rk_valid, 1'b1);
    chk("t4_zero_round", 128'(rk_round), 128'(1));
    chk("t4_zero_key", rk_out, 128'h62636363626363636263636362636363);

    // start held high: back-to-back runs, rcon restarts
    do_reset();
    run_tied("t5", 0, 1'b1, 70);

    // long stall on round 0
    do_reset();
    @(negedge clk);
    start    = 1'b1;
    key_in   = KEY_A;
    rk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 100; k++) begin
      chk_bit("t6_valid", rk_valid, 1'b1);
      chk_bit("t6_busy", busy, 1'b1);
      chk("t6_round", 128'(rk_round), 128'h0);
      chk("t6_key", rk_out, KEY_A);
      @(negedge clk);
    end
    rk_ready = 1'b1;
    wait_n = 0;
    while (!done && wait_n < 80) begin
      @(negedge clk);
      wait_n++;
    end
    chk_bit("t6_done_after_release", done, 1'b1);
    chk("t6_final_key", rk_out, exp_key[10]);
    @(negedge clk);
    chk_bit("t6_idle", busy, 1'b0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
